addr_rf_scheduler: RTL
======================

# addr_rf_scheduler

Frame-level sequencer for the sparse-weight address-to-RF stage. It walks every output position (h, w) and every filter column s, and launches one AddrToRF conversion per non-empty column. It waits for each conversion to finish, then presents the resulting RF to the PE-array loader with a valid/ready handshake. It sits between the top-level controller (frame start/done) and the AddrToRF instance plus the weight-column memory that supplies its r/k/ptr/length.

## Interface
- IA_ROW, 16: max output rows/cols; position width HW = $clog2(IA_ROW)+1
- W_C_LENGTH, 256: max nonzeros per column; length width LW = $clog2(W_C_LENGTH)+1
- TIMEOUT, 1024: max cycles allowed in WAIT before error
- i_clk  in  1  clock, all logic on rising edge
- i_rst  in  1  reset, asynchronous, active-high
- i_start  in  1  frame start pulse; accepted only in IDLE
- i_h_max  in  HW  output rows in frame; sampled at accepted i_start
- i_w_max  in  HW  output cols in frame; sampled at accepted i_start
- i_s_num  in  2  filter columns (0..3); sampled at accepted i_start
- i_col_len  in  LW  nonzero count of column o_s, driven by the weight memory
- o_sub_start  out  1  one-cycle launch pulse to AddrToRF i_start
- o_h, o_w  out  HW  current output position to AddrToRF i_h/i_w
- o_s  out  2  current filter column; drives AddrToRF i_s and weight-memory select
- i_sub_finish  in  1  AddrToRF o_finish
- o_rf_valid  out  1  RF from AddrToRF is complete and stable
- i_rf_ready  in  1  loader accepts RF
- o_busy  out  1  high in every state except IDLE
- o_done  out  1  one-cycle pulse at frame end
- o_err  out  1  sticky error; cleared by the next accepted i_start
- o_job_cnt  out  16  launched conversions this frame; cleared at accepted i_start

## Operation
- States: IDLE, LAUNCH, WAIT, HOLD, DONE, ERR.
- IDLE: when i_start is high, latch h_max/w_max/s_num and zero the h/w/s counters, job count and o_err.
  - If any of h_max, w_max or s_num is 0, go to DONE.
  - Otherwise go to LAUNCH.
- LAUNCH: evaluate i_col_len.
  - If i_col_len == 0, skip the column: advance counters, with no pulse and no handshake. AddrToRF must never be started with length 0, because it would not terminate.
  - Otherwise assert o_sub_start for this cycle, increment o_job_cnt, clear the watchdog and go to WAIT.
- WAIT: on i_sub_finish go to HOLD.
  - The watchdog counts WAIT cycles. Reaching TIMEOUT goes to ERR.
- HOLD: o_rf_valid = 1. On i_rf_ready, advance counters.
- Advance order: s is innermost, then w, then h.
  - s wraps at s_num-1, w wraps at w_max-1, h at h_max-1.
  - After the last (h, w, s) go to DONE; otherwise go to LAUNCH.
- DONE: o_done = 1 for one cycle, then IDLE.
- ERR: o_err is set, then IDLE. No o_done is issued.
- i_start outside IDLE is ignored.
- i_sub_finish outside WAIT sets o_err but does not change state.
- o_h/o_w/o_s are registered and change only on advance. They are therefore stable from o_sub_start through the HOLD handshake, as AddrToRF requires.

## Timing
- Reset values: state IDLE, o_sub_start 0, o_h/o_w/o_s 0, o_rf_valid 0, o_busy 0, o_done 0, o_err 0, o_job_cnt 0.
- Reset mid-frame aborts immediately. No o_done is issued. AddrToRF is reset from the same source.
- Latency for a non-empty column:
  - Accepted i_start at edge 0 gives LAUNCH in cycle 1, with o_sub_start high in cycle 1.
  - o_rf_valid rises the cycle after i_sub_finish.
  - A handshake in cycle n gives the next LAUNCH in cycle n+1.
- Skipped column: 1 cycle in LAUNCH.
- o_rf_valid holds until i_rf_ready and never drops without a transfer. i_rf_ready may be high before valid.
- o_done is asserted the cycle after the final handshake or skip. o_busy falls in the following cycle.
- Throughput: one launch per AddrToRF duration (i_col_len cycles) + 3 cycles minimum.

## Structure
- Shared package (header.h): state enum, and HW/LW widths derived from IA_ROW and W_C_LENGTH.
- Natural sub-module: hw_s_counter, the nested (h, w, s) counter with advance input and last output. It is reusable by the output writeback sequencer.
- The watchdog stays inline.

## Test plan
- h_max=2, w_max=2, s_num=3, all i_col_len=4, i_rf_ready tied 1 -> 12 o_sub_start pulses in order (0,0,0),(0,0,1)...(1,1,2); o_job_cnt=12; one o_done.
- Same frame with i_col_len=0 whenever o_s==1 -> 8 launches, s=1 never started, o_done still issued.
- i_rf_ready low for 5 cycles in HOLD -> o_rf_valid stays 1, o_h/o_w/o_s unchanged, advance exactly one cycle after ready rises.
- i_s_num=0 -> o_done one cycle after LAUNCH-less IDLE exit, o_job_cnt=0, no o_sub_start.
- i_sub_finish withheld, TIMEOUT=16 -> o_err=1 after 16 WAIT cycles, return to IDLE, no o_done; next i_start clears o_err.
- i_rst pulsed mid-WAIT, plus a second i_start while busy -> all outputs at reset values asynchronously; the busy-time start is ignored.

Source files
------------

// File: rtl/addr_rf_scheduler_pkg.sv
// ============================================================================
//  addr_rf_scheduler_pkg
//  Shared state encoding and width helpers for the address-to-RF sequencer.
//  Revision: 1.0
// ============================================================================
`default_nettype none

package addr_rf_scheduler_pkg;

   typedef enum logic [2:0] {
      ST_IDLE   = 3'd0,
      ST_LAUNCH = 3'd1,
      ST_WAIT   = 3'd2,
      ST_HOLD   = 3'd3,
      ST_DONE   = 3'd4,
      ST_ERR    = 3'd5
   } state_e;

   localparam int S_W   = 2;
   localparam int JOB_W = 16;

   // Widths carry one spare bit so the maximum count itself is representable.
   function automatic int pos_width(input int ia_row);
      return $clog2(ia_row) + 1;
   endfunction

   function automatic int len_width(input int w_c_length);
      return $clog2(w_c_length) + 1;
   endfunction

endpackage

`default_nettype wire

// File: rtl/addr_rf_scheduler_hw_s_counter.sv
// ============================================================================
//  hw_s_counter
//  Nested (h, w, s) position counter: s innermost, then w, then h.
//  Revision: 1.0
// ============================================================================
`default_nettype none

module hw_s_counter
   import addr_rf_scheduler_pkg::*;
#(
   parameter int HW = 5
) (
   input  logic          i_clk,
   input  logic          i_rst,
   input  logic          i_load,
   input  logic [HW-1:0] i_h_max,
   input  logic [HW-1:0] i_w_max,
   input  logic [S_W-1:0] i_s_num,
   input  logic          i_advance,
   output logic [HW-1:0] o_h,
   output logic [HW-1:0] o_w,
   output logic [S_W-1:0] o_s,
   output logic          o_last
);

   logic [HW-1:0]  h_q, h_d, w_q, w_d, h_max_q, h_max_d, w_max_q, w_max_d;
   logic [S_W-1:0] s_q, s_d, s_num_q, s_num_d;
   logic [HW-1:0]  w_h_last, w_w_last;
   logic [S_W-1:0] w_s_last;

   assign w_h_last = h_max_q - 1'b1;
   assign w_w_last = w_max_q - 1'b1;
   assign w_s_last = s_num_q - 1'b1;

   always_comb begin
      h_d     = h_q;
      w_d     = w_q;
      s_d     = s_q;
      h_max_d = h_max_q;
      w_max_d = w_max_q;
      s_num_d = s_num_q;
      if (i_load) begin
         h_d     = '0;
         w_d     = '0;
         s_d     = '0;
         h_max_d = i_h_max;
         w_max_d = i_w_max;
         s_num_d = i_s_num;
      end else if (i_advance) begin
         if (s_q == w_s_last) begin
            s_d = '0;
            if (w_q == w_w_last) begin
               w_d = '0;
               h_d = (h_q == w_h_last) ? '0 : h_q + 1'b1;
            end else begin
               w_d = w_q + 1'b1;
            end
         end else begin
            s_d = s_q + 1'b1;
         end
      end
   end

   always_ff @(posedge i_clk or posedge i_rst) begin
      if (i_rst) begin
         h_q     <= '0;
         w_q     <= '0;
         s_q     <= '0;
         h_max_q <= '0;
         w_max_q <= '0;
         s_num_q <= '0;
      end else begin
         h_q     <= h_d;
         w_q     <= w_d;
         s_q     <= s_d;
         h_max_q <= h_max_d;
         w_max_q <= w_max_d;
         s_num_q <= s_num_d;
      end
   end

   assign o_h    = h_q;
   assign o_w    = w_q;
   assign o_s    = s_q;
   assign o_last = (s_q == w_s_last) && (w_q == w_w_last) && (h_q == w_h_last);

endmodule

`default_nettype wire

// File: rtl/addr_rf_scheduler.sv
// ============================================================================
//  addr_rf_scheduler
//  Frame sequencer launching one AddrToRF conversion per non-empty column.
//  Revision: 1.0
// ============================================================================
`default_nettype none

module addr_rf_scheduler
   import addr_rf_scheduler_pkg::*;
#(
   parameter int  IA_ROW     = 16,
   parameter int  W_C_LENGTH = 256,
   parameter int  TIMEOUT    = 1024,
   localparam int HW         = pos_width(IA_ROW),
   localparam int LW         = len_width(W_C_LENGTH)
) (
   input  logic             i_clk,
   input  logic             i_rst,
   input  logic             i_start,
   input  logic [HW-1:0]    i_h_max,
   input  logic [HW-1:0]    i_w_max,
   input  logic [S_W-1:0]   i_s_num,
   input  logic [LW-1:0]    i_col_len,
   output logic             o_sub_start,
   output logic [HW-1:0]    o_h,
   output logic [HW-1:0]    o_w,
   output logic [S_W-1:0]   o_s,
   input  logic             i_sub_finish,
   output logic             o_rf_valid,
   input  logic             i_rf_ready,
   output logic             o_busy,
   output logic             o_done,
   output logic             o_err,
   output logic [JOB_W-1:0] o_job_cnt
);

   localparam int              WD_W     = $clog2(TIMEOUT + 1);
   localparam logic [WD_W-1:0] WD_LIMIT = WD_W'(TIMEOUT - 1);

   state_e            state_q, state_d;
   logic [JOB_W-1:0]  job_cnt_q, job_cnt_d;
   logic [WD_W-1:0]   wdog_q, wdog_d;
   logic              err_q, err_d;
   logic              w_cnt_load, w_cnt_adv, w_cnt_last, w_sub_start;

   hw_s_counter #(
      .HW (HW)
   ) u_hw_s_counter (
      .i_clk     (i_clk),
      .i_rst     (i_rst),
      .i_load    (w_cnt_load),
      .i_h_max   (i_h_max),
      .i_w_max   (i_w_max),
      .i_s_num   (i_s_num),
      .i_advance (w_cnt_adv),
      .o_h       (o_h),
      .o_w       (o_w),
      .o_s       (o_s),
      .o_last    (w_cnt_last)
   );

   always_comb begin
      state_d     = state_q;
      job_cnt_d   = job_cnt_q;
      wdog_d      = wdog_q;
      err_d       = err_q;
      w_cnt_load  = 1'b0;
      w_cnt_adv   = 1'b0;
      w_sub_start = 1'b0;
      case (state_q)
         ST_IDLE: begin
            if (i_start) begin
               w_cnt_load = 1'b1;
               job_cnt_d  = '0;
               err_d      = 1'b0;
               state_d    = (i_h_max == '0 || i_w_max == '0 || i_s_num == '0)
                            ? ST_DONE : ST_LAUNCH;
            end
         end
         ST_LAUNCH: begin
            // A zero-length column would never finish in AddrToRF, so skip it.
            if (i_col_len == '0) begin
               w_cnt_adv = 1'b1;
               state_d   = w_cnt_last ? ST_DONE : ST_LAUNCH;
            end else begin
               w_sub_start = 1'b1;
               job_cnt_d   = job_cnt_q + 1'b1;
               wdog_d      = '0;
               state_d     = ST_WAIT;
            end
         end
         ST_WAIT: begin
            if (i_sub_finish) begin
               state_d = ST_HOLD;
            end else if (wdog_q == WD_LIMIT) begin
               state_d = ST_ERR;
               err_d   = 1'b1;
            end else begin
               wdog_d = wdog_q + 1'b1;
            end
         end
         ST_HOLD: begin
            if (i_rf_ready) begin
               w_cnt_adv = 1'b1;
               state_d   = w_cnt_last ? ST_DONE : ST_LAUNCH;
            end
         end
         ST_DONE: state_d = ST_IDLE;
         ST_ERR: begin
            err_d   = 1'b1;
            state_d = ST_IDLE;
         end
         default: state_d = ST_IDLE;
      endcase
      // A finish pulse with no conversion outstanding is a protocol error.
      if (i_sub_finish && state_q != ST_WAIT) begin
         err_d = 1'b1;
      end
   end

   always_ff @(posedge i_clk or posedge i_rst) begin
      if (i_rst) begin
         state_q   <= ST_IDLE;
         job_cnt_q <= '0;
         wdog_q    <= '0;
         err_q     <= 1'b0;
      end else begin
         state_q   <= state_d;
         job_cnt_q <= job_cnt_d;
         wdog_q    <= wdog_d;
         err_q     <= err_d;
      end
   end

   assign o_sub_start = w_sub_start;
   assign o_rf_valid  = (state_q == ST_HOLD);
   assign o_done      = (state_q == ST_DONE);
   assign o_busy      = (state_q != ST_IDLE);
   assign o_err       = err_q;
   assign o_job_cnt   = job_cnt_q;

endmodule

`default_nettype wire
